req_dispatch_4: RTL and testbench



---
 rtl/req_dispatch_4_pkg.sv | 17 +
 rtl/encoder_4.sv | 19 +
 rtl/req_dispatch_4.sv | 130 +++++++++++++
 tb/tb_req_dispatch_4.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/req_dispatch_4_pkg.sv
// Shared constants and types for the 4-source request dispatcher.
package req_dispatch_4_pkg;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT,
    StBusy  = ST_BUSY
  } state_e;

endpackage

// File: rtl/encoder_4.sv
// 4-input priority encoder; v1 has highest priority and maps to index 0.
module encoder_4 (
  input  logic v1,
  input  logic v2,
  input  logic v3,
  input  logic v4,
  output logic valid,
  output logic num1,
  output logic num2
);

  // Index {num1,num2} of the lowest-numbered active input.
  always_comb begin
    valid = v1 | v2 | v3 | v4;
    num1  = ~v1 & ~v2 & (v3 | v4);
    num2  = ~v1 & (v2 | (~v3 & v4));
  end

endmodule

// File: rtl/req_dispatch_4.sv
// Sticky request capture, priority grant handshake and one-job-at-a-time busy tracking.
module req_dispatch_4
  import req_dispatch_4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_ready,
  input  logic             done,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             enc_valid;
  logic             enc_num1;
  logic             enc_num2;
  logic [N_SRC-1:0] clr_mask;

  encoder_4 u_encoder_4 (
    .v1    (pending_q[0]),
    .v2    (pending_q[1]),
    .v3    (pending_q[2]),
    .v4    (pending_q[3]),
    .valid (enc_valid),
    .num1  (enc_num1),
    .num2  (enc_num2)
  );

  // Pending bits: clear on accepted grant, new request wins over the clear.
  always_comb begin
    clr_mask = '0;
    if (gnt_valid_q && gnt_ready) begin
      clr_mask[gnt_idx_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | req;
    overrun_d = overrun_q | (|(req & pending_q & ~clr_mask));
  end

  // Dispatch FSM next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enc_valid) begin
          gnt_idx_d   = {enc_num1, enc_num2};
          gnt_valid_d = 1'b1;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (gnt_ready) begin
          gnt_valid_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_dispatch_4.sv
// Directed-vector bench for req_dispatch_4 with a short timeout.
module tb_req_dispatch_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       gnt_ready;
  logic       done;
  logic       busy;
  logic [3:0] pending;
  logic       overrun;
  logic       timeout;

  int nvec = 0;
  int nmis = 0;

  req_dispatch_4 #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_ready (gnt_ready),
    .done      (done),
    .busy      (busy),
    .pending   (pending),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; gnt_ready = 1'b0; done = 1'b0;
    tick(); tick();
    chk("rst_gnt_valid", 8'(gnt_valid), 8'd0);
    chk("rst_gnt_idx", 8'(gnt_idx), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_overrun", 8'(overrun), 8'd0);
    chk("rst_timeout", 8'(timeout), 8'd0);
    rst = 1'b0;

    // Single request on source 2.
    req = 4'b0100; tick(); req = '0;
    chk("single_pending", 8'(pending), 8'h4);
    chk("single_no_gnt_yet", 8'(gnt_valid), 8'd0);
    tick();
    chk("single_gnt_valid", 8'(gnt_valid), 8'd1);
    chk("single_gnt_idx", 8'(gnt_idx), 8'd2);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    chk("single_accept_pending", 8'(pending), 8'h0);
    chk("single_busy", 8'(busy), 8'd1);
    chk("single_gnt_drop", 8'(gnt_valid), 8'd0);
    done = 1'b1; tick(); done = 1'b0;
    chk("single_done_busy", 8'(busy), 8'd0);
    tick();
    chk("single_idle_nognt", 8'(gnt_valid), 8'd0);

    // Priority and grant hold.
    req = 4'b1010; tick(); req = '0;
    chk("prio_pending", 8'(pending), 8'hA);
    tick();
    chk("prio_gnt_idx", 8'(gnt_idx), 8'd1);
    req = 4'b0001; tick(); req = '0;
    chk("hold_pending", 8'(pending), 8'hB);
    chk("hold_gnt_idx", 8'(gnt_idx), 8'd1);
    tick();
    chk("hold_gnt_valid", 8'(gnt_valid), 8'd1);
    chk("hold_gnt_idx2", 8'(gnt_idx), 8'd1);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    chk("hold_accept_pending", 8'(pending), 8'h9);
    done = 1'b1; tick(); done = 1'b0;
    chk("hold_done_busy", 8'(busy), 8'd0);
    tick();
    chk("next_gnt_valid", 8'(gnt_valid), 8'd1);
    chk("next_gnt_idx0", 8'(gnt_idx), 8'd0);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    chk("next_pending", 8'(pending), 8'h8);
    done = 1'b1; tick(); done = 1'b0;
    tick();
    chk("last_gnt_idx3", 8'(gnt_idx), 8'd3);
    chk("last_gnt_valid", 8'(gnt_valid), 8'd1);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    chk("last_busy", 8'(busy), 8'd1);

    // Timeout: done never comes.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_busy_hold", 8'(busy), 8'd1);
      chk("to_no_pulse_yet", 8'(timeout), 8'd0);
    end
    tick();
    chk("to_pulse", 8'(timeout), 8'd1);
    chk("to_busy_clr", 8'(busy), 8'd0);
    tick();
    chk("to_pulse_end", 8'(timeout), 8'd0);

    // Done coincides with the timeout cycle.
    req = 4'b0010; tick(); req = '0;
    tick();
    chk("tie_gnt_idx", 8'(gnt_idx), 8'd1);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    tick(); tick(); tick();
    chk("tie_busy_before", 8'(busy), 8'd1);
    done = 1'b1; tick(); done = 1'b0;
    chk("tie_no_timeout", 8'(timeout), 8'd0);
    chk("tie_busy_clr", 8'(busy), 8'd0);
    tick();
    chk("tie_still_no_timeout", 8'(timeout), 8'd0);
    chk("tie_idle_nognt", 8'(gnt_valid), 8'd0);

    // Overrun and set-wins.
    req = 4'b0001; tick();
    chk("ovr_first", 8'(overrun), 8'd0);
    tick(); req = '0;
    chk("ovr_set", 8'(overrun), 8'd1);
    chk("ovr_gnt_idx", 8'(gnt_idx), 8'd0);
    tick();
    chk("ovr_sticky", 8'(overrun), 8'd1);
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    req = 4'b0100; tick(); req = '0;
    tick();
    chk("sw_gnt_idx", 8'(gnt_idx), 8'd2);
    gnt_ready = 1'b1; req = 4'b0100; tick(); gnt_ready = 1'b0; req = '0;
    chk("sw_pending", 8'(pending), 8'h4);
    chk("sw_busy", 8'(busy), 8'd1);
    chk("sw_overrun_sticky", 8'(overrun), 8'd1);

    // Reset mid-busy with pending work.
    req = 4'b1000; tick(); req = '0;
    chk("rb_pending", 8'(pending), 8'hC);
    chk("rb_busy", 8'(busy), 8'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rb_pending_clr", 8'(pending), 8'h0);
    chk("rb_busy_clr", 8'(busy), 8'd0);
    chk("rb_overrun_clr", 8'(overrun), 8'd0);
    chk("rb_gnt_valid", 8'(gnt_valid), 8'd0);
    chk("rb_gnt_idx", 8'(gnt_idx), 8'd0);
    tick(); tick();
    chk("rb_no_grant", 8'(gnt_valid), 8'd0);
    req = 4'b0001; tick(); req = '0;
    tick();
    chk("rb_new_gnt", 8'(gnt_valid), 8'd1);
    chk("rb_new_idx", 8'(gnt_idx), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
